// File: rtl/ysyx_23060201_pkg.sv
// rtl/ysyx_23060201_pkg.sv - shared widths, source IDs and arbitration helper
package ysyx_23060201_pkg;

  localparam int DEF_GPR_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH     = 32;

  // Writeback source identifiers; also the encoding of the round-robin pointer.
  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // LSU wins when it is the only requester, or when both request and EXU was served last.
  function automatic logic lsu_wins(input logic exu_v, input logic lsu_v, input src_e last_src);
    return lsu_v && (!exu_v || (last_src == SRC_EXU));
  endfunction

endpackage

// File: rtl/ysyx_23060201_scoreboard.sv
// rtl/ysyx_23060201_scoreboard.sv - pending-register scoreboard, hazard check and sticky writeback error
module ysyx_23060201_scoreboard
  import ysyx_23060201_pkg::*;
#(
  parameter int GPR_ADDR_WIDTH = DEF_GPR_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_iss_valid,
  input  logic                      i_iss_wen,
  input  logic [GPR_ADDR_WIDTH-1:0] i_iss_rd,
  input  logic [1:0]                i_iss_ren,
  input  logic [GPR_ADDR_WIDTH-1:0] i_iss_rs1,
  input  logic [GPR_ADDR_WIDTH-1:0] i_iss_rs2,
  output logic                      o_iss_ready,
  input  logic                      i_wb_fire,
  input  logic [GPR_ADDR_WIDTH-1:0] i_wb_rd,
  input  logic                      i_clr_en,
  input  logic [GPR_ADDR_WIDTH-1:0] i_clr_addr,
  output logic                      o_sb_busy,
  output logic                      o_wb_err
);

  localparam int NREG = 1 << GPR_ADDR_WIDTH;

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_pend_nxt;
  logic            w_iss_ready;
  logic            w_set;
  logic            r_wb_err;

  // Hazard check: stall on any enabled source or destination that still has a write outstanding.
  always_comb begin
    w_iss_ready = !((i_iss_ren[0] && r_pend[i_iss_rs1]) ||
                    (i_iss_ren[1] && r_pend[i_iss_rs2]) ||
                    (i_iss_wen    && r_pend[i_iss_rd]));
    w_set       = i_iss_valid && w_iss_ready && i_iss_wen && (i_iss_rd != '0);
  end

  // Next pending vector: set is applied after clear so a same-cycle set wins; x0 never pends.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_set) begin
      w_set_mask[i_iss_rd] = 1'b1;
    end
    if (i_clr_en) begin
      w_clr_mask[i_clr_addr] = 1'b1;
    end
    w_pend_nxt    = (r_pend & ~w_clr_mask) | w_set_mask;
    w_pend_nxt[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  // Sticky error: a writeback arrived for a register nobody issued a write to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_err <= 1'b0;
    end else if (i_wb_fire && !r_pend[i_wb_rd]) begin
      r_wb_err <= 1'b1;
    end
  end

  assign o_iss_ready = w_iss_ready;
  assign o_sb_busy   = |r_pend;
  assign o_wb_err    = r_wb_err;

endmodule

// File: rtl/ysyx_23060201_gpr_wb_arb.sv
// rtl/ysyx_23060201_gpr_wb_arb.sv - EXU/LSU writeback arbiter with registered GPR write port
module ysyx_23060201_gpr_wb_arb
  import ysyx_23060201_pkg::*;
#(
  parameter int GPR_ADDR_WIDTH = DEF_GPR_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iss_valid,
  input  logic                      iss_wen,
  input  logic [GPR_ADDR_WIDTH-1:0] iss_rd,
  input  logic [1:0]                iss_ren,
  input  logic [GPR_ADDR_WIDTH-1:0] iss_rs1,
  input  logic [GPR_ADDR_WIDTH-1:0] iss_rs2,
  output logic                      iss_ready,
  input  logic                      exu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0]     exu_data,
  output logic                      exu_ready,
  input  logic                      lsu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]     lsu_data,
  output logic                      lsu_ready,
  output logic                      gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata,
  output logic                      sb_busy,
  output logic                      wb_err
);

  src_e                      r_last;
  logic                      w_grant_exu;
  logic                      w_grant_lsu;
  logic                      w_xfer;
  logic [GPR_ADDR_WIDTH-1:0] w_xfer_rd;
  logic [DATA_WIDTH-1:0]     w_xfer_data;
  logic                      w_wb_fire;
  logic                      r_gpr_wen;
  logic [GPR_ADDR_WIDTH-1:0] r_gpr_waddr;
  logic [DATA_WIDTH-1:0]     r_gpr_wdata;

  // Grants come only from the valids and the pointer, never from a ready, so there is no loop.
  always_comb begin
    w_grant_lsu = lsu_wins(exu_valid, lsu_valid, r_last);
    w_grant_exu = exu_valid && !w_grant_lsu;
    w_xfer      = w_grant_exu || w_grant_lsu;
    w_xfer_rd   = w_grant_lsu ? lsu_rd   : exu_rd;
    w_xfer_data = w_grant_lsu ? lsu_data : exu_data;
    w_wb_fire   = w_xfer && (w_xfer_rd != '0);
  end

  // Round-robin pointer remembers the last source actually served; reset leaves EXU favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= SRC_LSU;
    end else if (w_xfer) begin
      r_last <= w_grant_lsu ? SRC_LSU : SRC_EXU;
    end
  end

  // GPR write register: one-cycle pulse per accepted non-x0 writeback, address/data hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpr_wen   <= 1'b0;
      r_gpr_waddr <= '0;
      r_gpr_wdata <= '0;
    end else begin
      r_gpr_wen <= w_wb_fire;
      if (w_wb_fire) begin
        r_gpr_waddr <= w_xfer_rd;
        r_gpr_wdata <= w_xfer_data;
      end
    end
  end

  // The pending bit is released by the registered write, so readers unstall after the GPR is updated.
  ysyx_23060201_scoreboard #(
    .GPR_ADDR_WIDTH(GPR_ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_iss_valid(iss_valid),
    .i_iss_wen  (iss_wen),
    .i_iss_rd   (iss_rd),
    .i_iss_ren  (iss_ren),
    .i_iss_rs1  (iss_rs1),
    .i_iss_rs2  (iss_rs2),
    .o_iss_ready(iss_ready),
    .i_wb_fire  (w_wb_fire),
    .i_wb_rd    (w_xfer_rd),
    .i_clr_en   (r_gpr_wen),
    .i_clr_addr (r_gpr_waddr),
    .o_sb_busy  (sb_busy),
    .o_wb_err   (wb_err)
  );

  assign exu_ready = w_grant_exu;
  assign lsu_ready = w_grant_lsu;
  assign gpr_wen   = r_gpr_wen;
  assign gpr_waddr = r_gpr_waddr;
  assign gpr_wdata = r_gpr_wdata;

endmodule

// File: tb/tb_ysyx_23060201_gpr_wb_arb.sv
// tb/tb_ysyx_23060201_gpr_wb_arb.sv - self-checking bench with behavioural scoreboard/arbiter model
module tb_ysyx_23060201_gpr_wb_arb;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic        iss_wen;
  logic [4:0]  iss_rd;
  logic [1:0]  iss_ren;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic        iss_ready;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        sb_busy;
  logic        wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_23060201_gpr_wb_arb dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd), .iss_ren(iss_ren),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_ready(iss_ready),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .sb_busy(sb_busy), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: set of outstanding registers, last served source, expected write port.
  logic [31:0] m_pend, n_pend;
  logic        m_gwen, n_gwen;
  logic [4:0]  m_waddr, n_waddr;
  logic [31:0] m_wdata, n_wdata;
  logic        m_err, n_err;
  logic        m_last_lsu, n_last_lsu;
  bit          m_valid = 0;
  bit          n_ok = 0;

  always @(negedge clk) begin : compare
    logic e_ready, g_exu, g_lsu, any;
    logic [4:0]  x_rd;
    logic [31:0] x_data;
    #2;
    e_ready = m_valid && !((iss_ren[0] && m_pend[iss_rs1]) || (iss_ren[1] && m_pend[iss_rs2]) ||
                           (iss_wen && m_pend[iss_rd]));
    if (exu_valid && lsu_valid) begin
      g_exu = m_last_lsu;
      g_lsu = !m_last_lsu;
    end else begin
      g_exu = exu_valid;
      g_lsu = lsu_valid;
    end
    any    = g_exu || g_lsu;
    x_rd   = g_lsu ? lsu_rd : exu_rd;
    x_data = g_lsu ? lsu_data : exu_data;
    if (m_valid) begin
      chk("model_iss_ready", iss_ready, e_ready);
      chk("model_exu_ready", exu_ready, g_exu);
      chk("model_lsu_ready", lsu_ready, g_lsu);
      chk("model_gpr_wen", gpr_wen, m_gwen);
      chk("model_gpr_waddr", gpr_waddr, m_waddr);
      chk("model_gpr_wdata", gpr_wdata, m_wdata);
      chk("model_sb_busy", sb_busy, m_pend != 0);
      chk("model_wb_err", wb_err, m_err);
    end
    if (rst) begin
      n_ok = 1; n_pend = 0; n_gwen = 0; n_waddr = 0; n_wdata = 0; n_err = 0; n_last_lsu = 1;
    end else if (m_valid) begin
      n_ok = 1;
      n_pend = m_pend;
      if (m_gwen) n_pend[m_waddr] = 1'b0;
      if (iss_valid && e_ready && iss_wen && iss_rd != 0) n_pend[iss_rd] = 1'b1;
      n_err = m_err;
      n_gwen = 0; n_waddr = m_waddr; n_wdata = m_wdata;
      if (any && x_rd != 0) begin
        if (!m_pend[x_rd]) n_err = 1;
        n_gwen = 1; n_waddr = x_rd; n_wdata = x_data;
      end
      n_last_lsu = any ? g_lsu : m_last_lsu;
    end else begin
      n_ok = 0;
    end
  end

  always @(posedge clk) begin : model_apply
    if (n_ok) begin
      m_valid = 1; m_pend = n_pend; m_gwen = n_gwen; m_waddr = n_waddr;
      m_wdata = n_wdata; m_err = n_err; m_last_lsu = n_last_lsu;
    end
  end

  task automatic idle_inputs();
    rst = 0; iss_valid = 0; iss_wen = 0; iss_rd = 0; iss_ren = 0; iss_rs1 = 0; iss_rs2 = 0;
    exu_valid = 0; exu_rd = 0; exu_data = 0; lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk); idle_inputs(); rst = 1;
    #3 chk("rst_iss_ready", iss_ready, 1);
    @(negedge clk); rst = 0;
    #3 chk("rst_gpr_wen", gpr_wen, 0);
    chk("rst_sb_busy", sb_busy, 0);
    chk("rst_wb_err", wb_err, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  bit exu_act, lsu_act, exu_done, lsu_done;

  initial begin : stim
    idle_inputs(); rst = 1;

    // RAW stall released two cycles after the writeback transfer.
    reset_dut();
    @(negedge clk); iss_valid = 1; iss_wen = 1; iss_rd = 5;
    #3 chk("raw_issue_ready", iss_ready, 1);
    @(negedge clk); iss_wen = 0; iss_ren = 2'b01; iss_rs1 = 5;
    #3 chk("raw_stall", iss_ready, 0); chk("raw_busy", sb_busy, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #3 chk("raw_hold", iss_ready, 0);
    end
    @(negedge clk); exu_valid = 1; exu_rd = 5; exu_data = 32'h1234;
    #3 chk("raw_exu_ready", exu_ready, 1); chk("raw_stall_n", iss_ready, 0);
    @(negedge clk); exu_valid = 0;
    #3 chk("raw_wen_n1", gpr_wen, 1); chk("raw_waddr_n1", gpr_waddr, 5);
    chk("raw_wdata_n1", gpr_wdata, 32'h1234); chk("raw_stall_n1", iss_ready, 0);
    @(negedge clk);
    #3 chk("raw_ready_n2", iss_ready, 1); chk("raw_wen_n2", gpr_wen, 0);
    @(negedge clk); idle_inputs();

    // Round-robin with both sources valid from a fresh pointer.
    reset_dut();
    for (int r = 1; r <= 5; r++) begin
      @(negedge clk); iss_valid = 1; iss_wen = 1; iss_rd = 5'(r);
    end
    @(negedge clk); idle_inputs();
    exu_valid = 1; exu_rd = 1; exu_data = 32'hA; lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB;
    #3 chk("rr1_exu", exu_ready, 1); chk("rr1_lsu", lsu_ready, 0);
    @(negedge clk); exu_rd = 3; exu_data = 32'hC;
    #3 chk("rr2_lsu", lsu_ready, 1); chk("rr2_exu", exu_ready, 0);
    chk("rr2_waddr", gpr_waddr, 1); chk("rr2_wdata", gpr_wdata, 32'hA);
    @(negedge clk); lsu_rd = 4; lsu_data = 32'hD;
    #3 chk("rr3_exu", exu_ready, 1); chk("rr3_waddr", gpr_waddr, 2); chk("rr3_wdata", gpr_wdata, 32'hB);
    @(negedge clk); exu_rd = 5; exu_data = 32'hE;
    #3 chk("rr4_lsu", lsu_ready, 1); chk("rr4_waddr", gpr_waddr, 3); chk("rr4_wdata", gpr_wdata, 32'hC);
    @(negedge clk); lsu_valid = 0;
    #3 chk("rr5_exu", exu_ready, 1); chk("rr5_wen", gpr_wen, 1);
    chk("rr5_waddr", gpr_waddr, 4); chk("rr5_wdata", gpr_wdata, 32'hD);
    @(negedge clk); exu_valid = 0;
    #3 chk("rr6_waddr", gpr_waddr, 5); chk("rr_err", wb_err, 0);

    // Writeback to x0 is consumed and dropped.
    reset_dut();
    @(negedge clk); iss_valid = 1; iss_wen = 1; iss_rd = 6;
    @(negedge clk); idle_inputs(); exu_valid = 1; exu_rd = 0; exu_data = 32'hFFFF;
    #3 chk("x0_ready", exu_ready, 1); chk("x0_busy_before", sb_busy, 1);
    @(negedge clk); exu_valid = 0;
    #3 chk("x0_wen", gpr_wen, 0); chk("x0_err", wb_err, 0); chk("x0_busy_after", sb_busy, 1);

    // Unexpected writeback sets the sticky error.
    reset_dut();
    @(negedge clk); lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    #3 chk("err_lsu_ready", lsu_ready, 1);
    @(negedge clk); lsu_valid = 0;
    #3 chk("err_set", wb_err, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #3 chk("err_sticky", wb_err, 1);
    end

    // Reset right after an accepted transfer drops the write.
    reset_dut();
    @(negedge clk); iss_valid = 1; iss_wen = 1; iss_rd = 3;
    @(negedge clk); idle_inputs(); exu_valid = 1; exu_rd = 3; exu_data = 32'h33;
    #3 chk("mid_exu_ready", exu_ready, 1);
    @(negedge clk); exu_valid = 0; rst = 1;
    #3 chk("mid_wen_pre", gpr_wen, 1);
    @(negedge clk); rst = 0;
    #3 chk("mid_wen", gpr_wen, 0); chk("mid_busy", sb_busy, 0); chk("mid_err", wb_err, 0);

    // WAW stall on a pending destination.
    reset_dut();
    @(negedge clk); iss_valid = 1; iss_wen = 1; iss_rd = 9;
    @(negedge clk);
    #3 chk("waw_stall", iss_ready, 0);
    @(negedge clk);
    #3 chk("waw_hold", iss_ready, 0);
    @(negedge clk); exu_valid = 1; exu_rd = 9; exu_data = 32'h99;
    #3 chk("waw_stall_n", iss_ready, 0);
    @(negedge clk); exu_valid = 0;
    #3 chk("waw_stall_n1", iss_ready, 0); chk("waw_wen", gpr_wen, 1);
    @(negedge clk);
    #3 chk("waw_ready_n2", iss_ready, 1);
    @(negedge clk); idle_inputs();
    #3 chk("waw_reissued", sb_busy, 1);

    // Randomized traffic, checked cycle by cycle by the model.
    exu_act = 0; lsu_act = 0; exu_done = 0; lsu_done = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (exu_done) exu_act = 0;
      if (lsu_done) lsu_act = 0;
      rst = (c % 300 == 0) || ($urandom_range(0, 399) == 0);
      iss_valid = $urandom_range(0, 1);
      iss_wen = $urandom_range(0, 3) != 0;
      iss_rd = 5'($urandom_range(0, 7));
      iss_ren = 2'($urandom_range(0, 3));
      iss_rs1 = 5'($urandom_range(0, 7));
      iss_rs2 = 5'($urandom_range(0, 7));
      if (!exu_act && $urandom_range(0, 2) == 0) begin
        exu_act = 1; exu_rd = 5'($urandom_range(0, 7)); exu_data = $urandom;
      end
      if (!lsu_act && $urandom_range(0, 2) == 0) begin
        lsu_act = 1; lsu_rd = 5'($urandom_range(0, 7)); lsu_data = $urandom;
      end
      exu_valid = exu_act;
      lsu_valid = lsu_act;
      #1;
      exu_done = exu_valid && exu_ready;
      lsu_done = lsu_valid && lsu_ready;
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
